// File: rtl/mem_refill_arbiter_pkg.sv
// Shared types and constants for the memory refill arbiter: FSM state encoding,
// default burst and timeout sizes, and the round-robin index helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int DEF_BURST_LEN      = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;
    localparam int DEF_BEAT_CNT_W     = $clog2(DEF_BURST_LEN);
    localparam int DEF_TO_CNT_W       = $clog2(DEF_TIMEOUT_CYCLES + 1);

    // (base + off) mod n, valid for base < n and off <= n
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) begin
            s = s - n;
        end else begin
            s = s + 0;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_refill_arbiter_if.sv
// Memory-side refill port of the arbiter; master = arbiter, slave = memory.
interface mem_refill_arbiter_if #(
    parameter int ADR_WIDTH  = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_arb2mem;
    logic [ADR_WIDTH-1:0]  adr_arb2mem;
    logic                  ack_mem2arb;
    logic [DATA_WIDTH-1:0] dat_mem2arb;

    modport master (
        output req_arb2mem,
        output adr_arb2mem,
        input  ack_mem2arb,
        input  dat_mem2arb
    );

    modport slave (
        input  req_arb2mem,
        input  adr_arb2mem,
        output ack_mem2arb,
        output dat_mem2arb
    );
endinterface

// File: rtl/mem_refill_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after rr_ptr_i (wrapping),
// returned as one-hot, index and a valid flag.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
    output logic [NUM_REQ-1:0]         gnt_oh_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       vld_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // scan rr_ptr+1, rr_ptr+2, ... and keep the first requester found
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        vld_o     = 1'b0;
        cand_s    = '0;
        hit_s     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s    = IDX_W'(wrap_idx(int'(rr_ptr_i), k, NUM_REQ));
            hit_s     = !vld_o && req_i[cand_s];
            gnt_oh_o  = hit_s ? (ONE_HOT0 << cand_s) : gnt_oh_o;
            gnt_idx_o = hit_s ? cand_s : gnt_idx_o;
            vld_o     = vld_o | hit_s;
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter sharing one memory refill port among NUM_REQ cache controllers.
// Optional burst watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_refill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADR_WIDTH      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BURST_LEN      = DEF_BURST_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_cc2arb,
    input  logic [NUM_REQ*ADR_WIDTH-1:0]   adr_cc2arb,
    output logic [NUM_REQ-1:0]             ack_arb2cc,
    output logic [DATA_WIDTH-1:0]          dat_arb2cc,
    output logic [NUM_REQ-1:0]             err_arb2cc,
    output logic [NUM_REQ-1:0]             gnt_arb,
    mem_refill_arbiter_if.master           mem_if
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(BURST_LEN);

    arb_state_e             state_q;
    logic [NUM_REQ-1:0]     gnt_q;
    logic                   req_mem_q;
    logic [ADR_WIDTH-1:0]   adr_q;
    logic [BEAT_W-1:0]      beat_cnt_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       win_idx_q;

    logic [NUM_REQ-1:0]     pick_oh_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   pick_vld_s;
    logic [ADR_WIDTH-1:0]   adr_pick_s;
    logic                   burst_ack_s;
    logic                   beat_last_s;
    logic                   timeout_s;
    logic                   burst_end_s;

    mem_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i     (req_cc2arb),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_oh_o  (pick_oh_s),
        .gnt_idx_o (pick_idx_s),
        .vld_o     (pick_vld_s)
    );

    assign adr_pick_s  = adr_cc2arb[int'(pick_idx_s)*ADR_WIDTH +: ADR_WIDTH];
    assign burst_ack_s = (state_q == ST_BURST) && mem_if.ack_mem2arb;
    assign beat_last_s = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
    assign burst_end_s = (burst_ack_s && beat_last_s) || timeout_s;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0]    to_cnt_q;
    logic [NUM_REQ-1:0] err_q;

    assign timeout_s = (state_q == ST_BURST) && !mem_if.ack_mem2arb &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // count ack-less BURST cycles; the abort pulse lands in the RELEASE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= '0;
        end else begin
            err_q <= timeout_s ? gnt_q : '0;
            if ((state_q == ST_BURST) && !mem_if.ack_mem2arb && !timeout_s) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign err_arb2cc = err_q;
`else
    assign timeout_s  = 1'b0;
    assign err_arb2cc = '0;
`endif

    // arbitration FSM: grant, address latch, beat count and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            req_mem_q  <= 1'b0;
            adr_q      <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
            win_idx_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        state_q    <= ST_BURST;
                        gnt_q      <= pick_oh_s;
                        win_idx_q  <= pick_idx_s;
                        adr_q      <= adr_pick_s;
                        req_mem_q  <= 1'b1;
                        beat_cnt_q <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (burst_end_s) begin
                        state_q    <= ST_RELEASE;
                        gnt_q      <= '0;
                        req_mem_q  <= 1'b0;
                        beat_cnt_q <= '0;
                        rr_ptr_q   <= win_idx_q;
                    end else if (burst_ack_s) begin
                        beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                    end else begin
                        state_q <= ST_BURST;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    gnt_q      <= '0;
                    req_mem_q  <= 1'b0;
                    beat_cnt_q <= '0;
                end
            endcase
        end
    end

    assign gnt_arb            = gnt_q;
    assign mem_if.req_arb2mem = req_mem_q;
    assign mem_if.adr_arb2mem = adr_q;
    assign ack_arb2cc         = (state_q == ST_BURST) ? (gnt_q & {NUM_REQ{mem_if.ack_mem2arb}}) : '0;
    assign dat_arb2cc         = mem_if.dat_mem2arb;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Self-checking bench for mem_refill_arbiter: owner/beat-count reference model plus
// directed scenarios with hand-computed expectations.
module tb_mem_refill_arbiter;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_cc2arb = '0;
    logic [NR*AW-1:0]  adr_cc2arb = {32'h12345678, 32'hFF07BD08};
    logic [NR-1:0]     ack_arb2cc;
    logic [DW-1:0]     dat_arb2cc;
    logic [NR-1:0]     err_arb2cc;
    logic [NR-1:0]     gnt_arb;

    mem_refill_arbiter_if #(.ADR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    mem_refill_arbiter #(
        .NUM_REQ(NR), .ADR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_cc2arb (req_cc2arb),
        .adr_cc2arb (adr_cc2arb),
        .ack_arb2cc (ack_arb2cc),
        .dat_arb2cc (dat_arb2cc),
        .err_arb2cc (err_arb2cc),
        .gnt_arb    (gnt_arb),
        .mem_if     (mem_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: who owns the port, beats delivered, release cycle, last winner
    int            m_own = -1;
    int            m_last = NR - 1;
    int            m_beats = 0;
    int            m_idle = 0;
    bit            m_rel = 1'b0;
    logic [AW-1:0] m_adr = '0;
    logic [NR-1:0] m_err = '0;

    always @(posedge clk or negedge rst_n) begin : model
        int own, last, beats, idle, c;
        bit rel;
        logic [AW-1:0] adr;
        logic [NR-1:0] err;
        if (!rst_n) begin
            m_own <= -1; m_last <= NR - 1; m_beats <= 0; m_idle <= 0;
            m_rel <= 1'b0; m_adr <= '0; m_err <= '0;
        end else begin
            own = m_own; last = m_last; beats = m_beats; idle = m_idle;
            rel = m_rel; adr = m_adr; err = '0;
            if (rel) begin
                rel = 1'b0;
            end else if (own < 0) begin
                for (int k = 1; k <= NR; k++) begin
                    c = (last + k) % NR;
                    if (own < 0 && req_cc2arb[c]) begin
                        own = c; adr = adr_cc2arb[c*AW +: AW]; beats = 0; idle = 0;
                    end
                end
            end else if (mem_if.ack_mem2arb) begin
                beats++; idle = 0;
                if (beats == BL) begin last = own; own = -1; rel = 1'b1; end
            end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                idle++;
                if (idle == TO) begin err[own] = 1'b1; last = own; own = -1; rel = 1'b1; end
`endif
            end
            m_own <= own; m_last <= last; m_beats <= beats; m_idle <= idle;
            m_rel <= rel; m_adr <= adr; m_err <= err;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin : cmp
        logic [NR-1:0] oh;
        oh = '0;
        if (m_own >= 0) oh[m_own] = 1'b1;
        chk("gnt", 64'(gnt_arb), 64'(oh));
        chk("req_mem", 64'(mem_if.req_arb2mem), 64'(m_own >= 0));
        chk("adr_mem", 64'(mem_if.adr_arb2mem), 64'(m_adr));
        chk("ack_cc", 64'(ack_arb2cc), 64'(mem_if.ack_mem2arb ? oh : '0));
        chk("err_cc", 64'(err_arb2cc), 64'(m_err));
        chk("dat_cc", 64'(dat_arb2cc), 64'(mem_if.dat_mem2arb));
    end

    // observation counters used by the directed scenarios
    int ack_cnt0 = 0;
    int ack_cnt1 = 0;
    int err_cnt = 0;
    logic [NR-1:0] prev_gnt = '0;
    logic [NR-1:0] gq[$];

    always @(negedge clk) begin
        if (ack_arb2cc[0]) ack_cnt0 <= ack_cnt0 + 1;
        if (ack_arb2cc[1]) ack_cnt1 <= ack_cnt1 + 1;
        if (err_arb2cc != '0) err_cnt <= err_cnt + 1;
        if (gnt_arb != '0 && prev_gnt == '0) gq.push_back(gnt_arb);
        prev_gnt <= gnt_arb;
    end

    // memory responder: auto mode acks after mem_lat waiting cycles, else follows man_ack
    bit mem_auto = 1'b0;
    int mem_lat = 0;
    bit man_ack = 1'b0;

    initial begin
        int lat_cnt;
        lat_cnt = 0;
        mem_if.ack_mem2arb = 1'b0;
        mem_if.dat_mem2arb = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_auto) begin
                if (mem_if.req_arb2mem) begin
                    if (lat_cnt < mem_lat) begin
                        lat_cnt++;
                        mem_if.ack_mem2arb = 1'b0;
                    end else begin
                        mem_if.ack_mem2arb = 1'b1;
                        mem_if.dat_mem2arb = $urandom;
                    end
                end else begin
                    lat_cnt = 0;
                    mem_if.ack_mem2arb = 1'b0;
                end
            end else begin
                lat_cnt = 0;
                mem_if.ack_mem2arb = man_ack;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_cc2arb = '0; man_ack = 1'b0; mem_auto = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_burst_end(input string nm);
        int n;
        n = 0;
        while (!mem_if.req_arb2mem && n < 50) begin tick(); n++; end
        while (mem_if.req_arb2mem && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: burst still open after %0d cycles", nm, n);
        end
    endtask

    initial begin
        int a0, a1, e0, b, n;

        // reset values
        repeat (2) tick();
        chk("rst_gnt", 64'(gnt_arb), 64'(2'b00));
        chk("rst_req", 64'(mem_if.req_arb2mem), 64'(1'b0));
        chk("rst_adr", 64'(mem_if.adr_arb2mem), 64'(32'h0));
        chk("rst_ack", 64'(ack_arb2cc), 64'(2'b00));
        chk("rst_err", 64'(err_arb2cc), 64'(2'b00));

        // 1: single requester, memory waits 3 cycles then streams 4 beats
        do_reset();
        mem_lat = 3; mem_auto = 1'b1;
        a0 = ack_cnt0; a1 = ack_cnt1;
        req_cc2arb = 2'b01;
        tick();
        chk("t1_req_next_cycle", 64'(mem_if.req_arb2mem), 64'(1'b1));
        chk("t1_adr", 64'(mem_if.adr_arb2mem), 64'(32'hFF07BD08));
        chk("t1_gnt", 64'(gnt_arb), 64'(2'b01));
        wait_burst_end("t1_burst");
        req_cc2arb = 2'b00;
        chk("t1_beats0", 64'(ack_cnt0 - a0), 64'(4));
        chk("t1_beats1", 64'(ack_cnt1 - a1), 64'(0));
        chk("t1_req_low", 64'(mem_if.req_arb2mem), 64'(1'b0));
        repeat (2) tick();

        // 2: both requesting from reset -> 0,1,0,1
        do_reset();
        mem_lat = 0; mem_auto = 1'b1;
        b = gq.size();
        req_cc2arb = 2'b11;
        n = 0;
        while (gq.size() < b + 4 && n < 200) begin tick(); n++; end
        req_cc2arb = 2'b00;
        wait_burst_end("t2_last_burst");
        chk("t2_grant0", 64'(gq[b]),   64'(2'b01));
        chk("t2_grant1", 64'(gq[b+1]), 64'(2'b10));
        chk("t2_grant2", 64'(gq[b+2]), 64'(2'b01));
        chk("t2_grant3", 64'(gq[b+3]), 64'(2'b10));
        repeat (2) tick();

        // 3: owner drops its request after the second beat
        do_reset();
        mem_lat = 1; mem_auto = 1'b1;
        a0 = ack_cnt0;
        req_cc2arb = 2'b01;
        n = 0;
        while ((ack_cnt0 - a0) < 2 && n < 50) begin tick(); n++; end
        req_cc2arb = 2'b00;
        wait_burst_end("t3_burst");
        chk("t3_beats0", 64'(ack_cnt0 - a0), 64'(4));
        chk("t3_gnt_released", 64'(gnt_arb), 64'(2'b00));
        repeat (2) tick();

        // 4: stray acks in IDLE and RELEASE are ignored
        do_reset();
        a0 = ack_cnt0; a1 = ack_cnt1;
        man_ack = 1'b1;
        repeat (3) tick();
        chk("t4_idle_gnt", 64'(gnt_arb), 64'(2'b00));
        chk("t4_idle_req", 64'(mem_if.req_arb2mem), 64'(1'b0));
        chk("t4_idle_acks", 64'((ack_cnt0 - a0) + (ack_cnt1 - a1)), 64'(0));
        man_ack = 1'b0;
        req_cc2arb = 2'b01;
        tick();
        man_ack = 1'b1;
        repeat (4) tick();
        req_cc2arb = 2'b00;
        chk("t4_release_gnt", 64'(gnt_arb), 64'(2'b00));
        repeat (2) tick();
        man_ack = 1'b0;
        chk("t4_beats_first", 64'(ack_cnt0 - a0), 64'(4));
        chk("t4_after_stray_req", 64'(mem_if.req_arb2mem), 64'(1'b0));
        mem_lat = 0; mem_auto = 1'b1;
        req_cc2arb = 2'b01;
        tick();
        wait_burst_end("t4_second_burst");
        req_cc2arb = 2'b00;
        chk("t4_beats_total", 64'(ack_cnt0 - a0), 64'(8));
        repeat (2) tick();

        // 5: reset in the middle of a burst, then requester 1 alone
        do_reset();
        mem_lat = 0; mem_auto = 1'b1;
        a1 = ack_cnt1;
        req_cc2arb = 2'b01;
        n = 0;
        while ((ack_cnt0 - a0) < 10 && n < 50) begin tick(); n++; end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_gnt", 64'(gnt_arb), 64'(2'b00));
        chk("t5_rst_req", 64'(mem_if.req_arb2mem), 64'(1'b0));
        chk("t5_rst_adr", 64'(mem_if.adr_arb2mem), 64'(32'h0));
        chk("t5_rst_ack", 64'(ack_arb2cc), 64'(2'b00));
        chk("t5_rst_err", 64'(err_arb2cc), 64'(2'b00));
        mem_auto = 1'b0; man_ack = 1'b0;
        req_cc2arb = 2'b10;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("t5_gnt1", 64'(gnt_arb), 64'(2'b10));
        chk("t5_adr1", 64'(mem_if.adr_arb2mem), 64'(32'h12345678));
        mem_auto = 1'b1;
        wait_burst_end("t5_burst");
        req_cc2arb = 2'b00;
        chk("t5_beats1", 64'(ack_cnt1 - a1), 64'(4));
        repeat (2) tick();

        // 6: memory never acks
        do_reset();
        e0 = err_cnt;
        req_cc2arb = 2'b01;
        repeat (12) tick();
`ifdef MEM_ARB_TIMEOUT_EN
        chk("t6_err_pulses", 64'(err_cnt - e0), 64'(1));
        req_cc2arb = 2'b00;
        do_reset();
`else
        chk("t6_err_none", 64'(err_cnt - e0), 64'(0));
        chk("t6_req_held", 64'(mem_if.req_arb2mem), 64'(1'b1));
        chk("t6_gnt_held", 64'(gnt_arb), 64'(2'b01));
        man_ack = 1'b1;
        repeat (4) tick();
        man_ack = 1'b0;
        req_cc2arb = 2'b00;
        tick();
        chk("t6_req_drop", 64'(mem_if.req_arb2mem), 64'(1'b0));
`endif
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
